// File: rtl/snail_pattern_source.sv
// Stimulus source for the snail pattern detector: programmable-rate enable strobe
// plus one serial bit per strobe, taken from a rotating pattern register or a 16-bit LFSR.
module snail_pattern_source #(
  parameter int          DIV_W     = 24,
  parameter int          PATTERN_W = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIV_W-1:0]             div,
  input  logic                         mode,
  input  logic                         load,
  input  logic [PATTERN_W-1:0]         pattern_in,
  output logic                         en,
  output logic                         a,
  output logic [$clog2(PATTERN_W)-1:0] bit_idx,
  output logic                         wrap
);

  localparam int                IDX_W    = $clog2(PATTERN_W);
  // An all-zero seed would lock the LFSR, so it is forced to 1.
  localparam logic [15:0]       SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PATTERN_W - 1);

  logic [DIV_W-1:0]     r_cnt;
  logic                 r_en;
  logic                 r_wrap;
  logic [PATTERN_W-1:0] r_sr;
  logic [IDX_W-1:0]     r_idx;
  logic [15:0]          r_lfsr;

  logic [15:0]          w_lfsr_nxt;
  logic                 w_idx_last;

  // Fibonacci x^16+x^14+x^13+x^11+1, shifting right.
  assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  assign w_idx_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_en   <= 1'b0;
      r_wrap <= 1'b0;
      r_sr   <= '0;
      r_idx  <= '0;
      r_lfsr <= SEED;
    end else if (load) begin
      r_cnt  <= '0;
      r_en   <= 1'b0;
      r_wrap <= 1'b0;
      r_sr   <= pattern_in;
      r_idx  <= '0;
      r_lfsr <= SEED;
    end else begin
      // >= rather than == so a shrinking div fires at once instead of wrapping the counter.
      if (r_cnt >= div) begin
        r_en  <= 1'b1;
        r_cnt <= '0;
      end else begin
        r_en  <= 1'b0;
        r_cnt <= r_cnt + 1'b1;
      end
      // Both sources advance every strobe so a mode switch keeps bit_idx aligned.
      if (r_en) begin
        r_sr   <= {r_sr[PATTERN_W-2:0], r_sr[PATTERN_W-1]};
        r_idx  <= w_idx_last ? '0 : r_idx + 1'b1;
        r_wrap <= w_idx_last;
        r_lfsr <= w_lfsr_nxt;
      end else begin
        r_wrap <= 1'b0;
      end
    end
  end

  assign en      = r_en;
  assign wrap    = r_wrap;
  assign bit_idx = r_idx;
  assign a       = mode ? r_lfsr[0] : r_sr[PATTERN_W-1];

endmodule

// File: tb/tb_snail_pattern_source.sv
// Scoreboard bench for snail_pattern_source: stimulus queues expected per-strobe bits,
// a negedge monitor pops them on every en; timing corners are checked inline.
module tb_snail_pattern_source;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] div;
  logic        mode;
  logic        load;
  logic [15:0] pattern_in;
  logic        en;
  logic        a;
  logic [3:0]  bit_idx;
  logic        wrap;

  typedef struct {
    logic       a;
    logic [3:0] idx;
    logic       wrap;
    logic       chk_wrap;
  } exp_t;

  exp_t q[$];
  logic mon_en = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;

  snail_pattern_source #(.DIV_W(24), .PATTERN_W(16), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .div(div), .mode(mode), .load(load), .pattern_in(pattern_in),
    .en(en), .a(a), .bit_idx(bit_idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input int av, input int idx, input int wv, input int cw);
    exp_t e;
    e.a = av[0]; e.idx = idx[3:0]; e.wrap = wv[0]; e.chk_wrap = cw[0];
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic count_to_en(output int n);
    n = 0;
    do begin step(); n++; end while (!en && n < 2000);
  endtask

  task automatic wait_q(input string name, input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin step(); n++; end
    if (q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout with %0d strobes outstanding, expected 0", name, q.size());
      q.delete();
    end
  endtask

  // Monitor: each strobe while armed must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en && en) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_a", int'(a), int'(e.a));
        chk("strobe_idx", int'(bit_idx), int'(e.idx));
        if (e.chk_wrap) chk("strobe_wrap", int'(wrap), int'(e.wrap));
      end
    end
  end

  initial begin
    int n;
    logic [15:0] pat;
    rst = 1'b1; div = 24'd3; mode = 1'b0; load = 1'b0; pattern_in = '0;
    step(); step();

    // Reset state; a is sr MSB (0) in pattern mode and seed LSB (1) in LFSR mode.
    chk("rst_en", int'(en), 0);
    chk("rst_idx", int'(bit_idx), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_a_mode0", int'(a), 0);
    mode = 1'b1; #1;
    chk("rst_a_mode1", int'(a), 1);

    // LFSR from seed 0xACE1, div=0: bits 1,0,0,0,0,1 (states ACE1,5670,AB38,559C,2ACE,1567).
    div = 24'd0;
    push(1,0,0,1); push(0,1,0,1); push(0,2,0,1); push(0,3,0,1); push(0,4,0,1); push(1,5,0,1);
    mon_en = 1'b1;
    rst = 1'b0;
    wait_q("lfsr_seq", 20);
    mon_en = 1'b0;

    // Pattern 0xB000, div=3: first strobe 4 edges after load, then MSB-first bits.
    mode = 1'b0; div = 24'd3; pattern_in = 16'hB000; load = 1'b1;
    step(); load = 1'b0;
    chk("load_a", int'(a), 1);
    chk("load_idx", int'(bit_idx), 0);
    pat = 16'hB000;
    for (int i = 0; i < 18; i++) push(int'(pat[15 - (i % 16)]), i % 16, 0, 0);
    mon_en = 1'b1;
    count_to_en(n);
    chk("first_strobe_div3", n, 4);
    wait_q("pattern_b000", 200);
    mon_en = 1'b0;

    // Pattern 0x8001, div=0: strobe every cycle; wrap coincides with return to idx 0.
    div = 24'd0; pattern_in = 16'h8001; load = 1'b1;
    step(); load = 1'b0;
    for (int s = 0; s < 20; s++)
      push(((s % 16) == 0 || (s % 16) == 15) ? 1 : 0, s % 16, (s == 16) ? 1 : 0, 1);
    mon_en = 1'b1;
    wait_q("pattern_8001", 50);
    mon_en = 1'b0;

    // Shrinking div mid-count fires on the next edge, then period 11.
    div = 24'd1000; pattern_in = 16'h1234; load = 1'b1;
    step(); load = 1'b0;
    repeat (500) step();
    chk("div1000_idle", int'(en), 0);
    div = 24'd10;
    step();
    chk("div_shrink_en", int'(en), 1);
    count_to_en(n);
    chk("div10_period", n, 11);

    // Load coinciding with a strobe: no advance, restart from new pattern.
    div = 24'd3; pattern_in = 16'hFFFF; load = 1'b1;
    step(); load = 1'b0;
    count_to_en(n);
    count_to_en(n);
    chk("second_strobe_gap", n, 4);
    chk("second_strobe_idx", int'(bit_idx), 1);
    load = 1'b1; pattern_in = 16'h4000;
    step();
    chk("load_on_en_en", int'(en), 0);
    chk("load_on_en_idx", int'(bit_idx), 0);
    chk("load_on_en_a", int'(a), 0);
    chk("load_on_en_wrap", int'(wrap), 0);
    load = 1'b0;
    count_to_en(n);
    chk("load_on_en_gap", n, 4);
    chk("load_on_en_strobe_idx", int'(bit_idx), 0);
    chk("load_on_en_strobe_a", int'(a), 0);

    // Reset mid-pattern with en high at bit_idx 7.
    div = 24'd0; pattern_in = 16'hFFFF; load = 1'b1;
    step(); load = 1'b0;
    n = 0;
    while (bit_idx != 4'd7 && n < 50) begin step(); n++; end
    chk("mid_idx7", int'(bit_idx), 7);
    chk("mid_en", int'(en), 1);
    rst = 1'b1;
    step();
    chk("midrst_en", int'(en), 0);
    chk("midrst_idx", int'(bit_idx), 0);
    chk("midrst_a", int'(a), 0);
    chk("midrst_wrap", int'(wrap), 0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
